// File: rtl/float_to_twos.sv
// Decodes the compact sign/exponent/significand float back to OUT_W-bit two's complement.
// A serial shifter rebuilds the magnitude, then the sign is applied before the result is offered.
module float_to_twos #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [SIG_W-1:0] sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] d
);

  // The largest shifted significand plus a sign bit must fit in the output word.
  if (OUT_W < SIG_W + (32'd1 << EXP_W)) begin : g_width_check
    $error("float_to_twos: OUT_W too small for SIG_W and EXP_W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [OUT_W-1:0] OUT_ONE = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] CNT_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [OUT_W-1:0]   mag_r;
  logic [EXP_W-1:0]   cnt_r;
  logic               sign_r;

  // Two's-complement negation of the magnitude; a zero magnitude stays zero.
  function automatic logic [OUT_W-1:0] apply_sign(input logic neg, input logic [OUT_W-1:0] m);
    if (neg) begin
      return ~m + OUT_ONE;
    end else begin
      return m;
    end
  endfunction

  // Control FSM with registered handshake outputs and the serial magnitude shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      d         <= {OUT_W{1'b0}};
      mag_r     <= {OUT_W{1'b0}};
      cnt_r     <= {EXP_W{1'b0}};
      sign_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            sign_r   <= sign;
            mag_r    <= {{(OUT_W-SIG_W){1'b0}}, sig};
            cnt_r    <= exp;
            in_ready <= 1'b0;
            state_r  <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          in_ready <= 1'b0;
          if (cnt_r != {EXP_W{1'b0}}) begin
            mag_r <= mag_r << 1;
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            state_r <= CONVERT;
          end
        end
        CONVERT: begin
          in_ready  <= 1'b0;
          d         <= apply_sign(sign_r, mag_r);
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          // d is left untouched here so it stays stable under back-pressure.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_twos.sv
// Randomised and directed bench for float_to_twos, checked every cycle against a
// transaction-level model built from value = (-1)^sign * sig * 2^exp and the exp+2 latency.
module tb_float_to_twos;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [2:0]  exp = 3'd0;
  logic [3:0]  sig = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] d;

  int n_checks = 0;
  int n_fail   = 0;

  float_to_twos #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(exp), .sig(sig),
    .out_valid(out_valid), .out_ready(out_ready), .d(d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference value from the number format itself.
  function automatic logic [11:0] ref_val(input bit s, input int e, input int g);
    int v;
    v = g * (2 ** e);
    if (s) v = -v;
    return v[11:0];
  endfunction

  // Transaction-level model: busy for exp+2 edges after accept, then offers the value.
  logic        m_ready, m_valid, m_busy;
  logic [11:0] m_d, m_pend;
  int          m_cd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0;
      m_d <= 12'h000; m_pend <= 12'h000; m_cd <= 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_busy) begin
      if (m_cd == 1) begin
        m_valid <= 1'b1;
        m_d     <= m_pend;
        m_busy  <= 1'b0;
      end
      m_cd <= m_cd - 1;
    end else if (in_valid && m_ready) begin
      m_busy  <= 1'b1;
      m_ready <= 1'b0;
      m_cd    <= int'(exp) + 2;
      m_pend  <= ref_val(sign, int'(exp), int'(sig));
    end
  end

  // Single compare process: reset values during rst, model values otherwise.
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'h000);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("d", 32'(d), 32'(m_d));
        if (out_valid) chk("no_800", 32'(d == 12'h800), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One transaction: accept, garbage pulse during busy, optional stall, handshake.
  task automatic send(input bit s, input int e, input int g, input int stall);
    int n;
    n = 0;
    while (!m_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("wait_ready_timeout", 32'd1, 32'd0);
    sign = s; exp = 3'(e); sig = 4'(g); in_valid = 1'b1;
    tick();
    sign = 1'($urandom); exp = 3'($urandom); sig = 4'($urandom); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = (stall == 0);
    n = 0;
    while (!m_valid && n < 50) begin tick(); n++; end
    if (n >= 50) chk("wait_valid_timeout", 32'd1, 32'd0);
    if (m_valid && stall > 0) begin
      repeat (stall) tick();
      out_ready = 1'b1;
    end
    n = 0;
    while (m_valid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("wait_hs_timeout", 32'd1, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Pin the reference model with hand-computed values.
    chk("pin_pos_80", 32'(ref_val(1'b0, 3, 4'hA)), 32'h050);
    chk("pin_neg_1920", 32'(ref_val(1'b1, 7, 4'hF)), 32'h880);
    chk("pin_neg_1", 32'(ref_val(1'b1, 0, 4'h1)), 32'hFFF);
    chk("pin_negzero", 32'(ref_val(1'b1, 5, 4'h0)), 32'h000);
    chk("pin_pos_4", 32'(ref_val(1'b0, 1, 4'h2)), 32'h004);

    // Async reset before any clock edge.
    #3 rst = 1'b1;
    #20 rst = 1'b0;
    tick();

    send(1'b0, 3, 4'hA, 0);
    send(1'b1, 7, 4'hF, 0);
    send(1'b1, 0, 4'h1, 1);
    send(1'b1, 5, 4'h0, 4);

    // Reset mid-SHIFT drops the word; the next word decodes normally.
    sign = 1'b0; exp = 3'd6; sig = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    repeat (12) tick();
    send(1'b0, 1, 4'h2, 0);

    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
           int'($urandom_range(3, 0)));
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
